// File: rtl/reg_alu_seq_if.sv
// Bundle between the execute/write-back sequencer, its requester and the register file.
// REG_ALU_SEQ_OVF_TRAP_EN adds the ovf_trap signal.
interface reg_alu_seq_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] rd;
    logic [2:0]        alu_op;
    logic [ADDR_W-1:0] R_Addr_A;
    logic [ADDR_W-1:0] R_Addr_B;
    logic [DATA_W-1:0] R_Data_A;
    logic [DATA_W-1:0] R_Data_B;
    logic              Reg_Write;
    logic [ADDR_W-1:0] W_Addr;
    logic [DATA_W-1:0] W_Data;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              ZF;
    logic              OF;
    logic              CF;
    logic [CNT_W-1:0]  retired_cnt;
`ifdef REG_ALU_SEQ_OVF_TRAP_EN
    logic              ovf_trap;
`endif

    modport slave (
`ifdef REG_ALU_SEQ_OVF_TRAP_EN
        output ovf_trap,
`endif
        input  in_valid, rs, rt, rd, alu_op, R_Data_A, R_Data_B,
        output in_ready, R_Addr_A, R_Addr_B, Reg_Write, W_Addr, W_Data,
        output done, result, ZF, OF, CF, retired_cnt
    );

    modport master (
`ifdef REG_ALU_SEQ_OVF_TRAP_EN
        input  ovf_trap,
`endif
        output in_valid, rs, rt, rd, alu_op, R_Data_A, R_Data_B,
        input  in_ready, R_Addr_A, R_Addr_B, Reg_Write, W_Addr, W_Data,
        input  done, result, ZF, OF, CF, retired_cnt
    );
endinterface

// File: rtl/reg_alu_seq.sv
// Four-state IDLE/READ/EXEC/WB sequencer: reads two registers, runs one ALU op, writes back.
// Optional macro REG_ALU_SEQ_OVF_TRAP_EN suppresses ADD/SUB overflow write-back and pulses ovf_trap.
module reg_alu_seq #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input logic         clk_Regs,
    input logic         rst_n,
    reg_alu_seq_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_SLL = 3'b111;

    localparam int MSB = DATA_W - 1;

    logic [1:0]               r_state;
    logic [ADDR_W-1:0]        r_rs;
    logic [ADDR_W-1:0]        r_rt;
    logic [ADDR_W-1:0]        r_rd;
    logic [2:0]               r_op;
    logic signed [DATA_W-1:0] r_opA;
    logic signed [DATA_W-1:0] r_opB;
    logic [DATA_W-1:0]        r_result;
    logic                     r_zf;
    logic                     r_of;
    logic                     r_cf;
    logic [CNT_W-1:0]         r_cnt;
    logic [DATA_W+1:0]        w_alu;
    logic                     w_wb;
    logic                     w_wr_ok;

    // Returns {CF, OF, result}; arithmetic is one bit wider so the carry/borrow falls out directly.
    function automatic logic [DATA_W+1:0] alu_eval(
        input logic [2:0]               op,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic [DATA_W:0]   ext;
        logic [DATA_W-1:0] res;
        logic              cf;
        logic              of;
        ext = '0;
        res = '0;
        cf  = 1'b0;
        of  = 1'b0;
        case (op)
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_NOR: res = ~(a | b);
            OP_ADD: begin
                ext = {1'b0, a} + {1'b0, b};
                res = ext[DATA_W-1:0];
                cf  = ext[DATA_W];
                of  = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
            end
            OP_SUB: begin
                ext = {1'b0, a} - {1'b0, b};
                res = ext[DATA_W-1:0];
                cf  = ext[DATA_W];
                of  = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
            end
            OP_SLT: res = {{(DATA_W-1){1'b0}}, (a < b)};
            OP_SLL: res = b << a[4:0];
            default: res = '0;
        endcase
        return {cf, of, res};
    endfunction

    assign w_alu = alu_eval(r_op, r_opA, r_opB);
    assign w_wb  = (r_state == S_WB);

`ifdef REG_ALU_SEQ_OVF_TRAP_EN
    logic r_trap;
    assign w_wr_ok      = !r_trap;
    assign bus.ovf_trap = w_wb && r_trap;
`else
    assign w_wr_ok = 1'b1;
`endif

    always_ff @(posedge clk_Regs or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_rs     <= '0;
            r_rt     <= '0;
            r_rd     <= '0;
            r_op     <= '0;
            r_opA    <= '0;
            r_opB    <= '0;
            r_result <= '0;
            r_zf     <= 1'b0;
            r_of     <= 1'b0;
            r_cf     <= 1'b0;
            r_cnt    <= '0;
`ifdef REG_ALU_SEQ_OVF_TRAP_EN
            r_trap   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (bus.in_valid) begin
                    r_rs    <= bus.rs;
                    r_rt    <= bus.rt;
                    r_rd    <= bus.rd;
                    r_op    <= bus.alu_op;
                    r_state <= S_READ;
                end
                S_READ: begin
                    r_opA   <= bus.R_Data_A;
                    r_opB   <= bus.R_Data_B;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_result <= w_alu[DATA_W-1:0];
                    r_zf     <= (w_alu[DATA_W-1:0] == '0);
                    r_of     <= w_alu[DATA_W];
                    r_cf     <= w_alu[DATA_W+1];
`ifdef REG_ALU_SEQ_OVF_TRAP_EN
                    r_trap   <= ((r_op == OP_ADD) || (r_op == OP_SUB)) && w_alu[DATA_W];
`endif
                    r_state  <= S_WB;
                end
                default: begin
                    r_cnt   <= r_cnt + 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake and write strobes decode straight from state so reset clears them at once.
    assign bus.in_ready    = (r_state == S_IDLE);
    assign bus.R_Addr_A    = r_rs;
    assign bus.R_Addr_B    = r_rt;
    assign bus.W_Addr      = r_rd;
    assign bus.W_Data      = r_result;
    assign bus.Reg_Write   = w_wb && (r_rd != '0) && w_wr_ok;
    assign bus.done        = w_wb;
    assign bus.result      = r_result;
    assign bus.ZF          = r_zf;
    assign bus.OF          = r_of;
    assign bus.CF          = r_cf;
    assign bus.retired_cnt = r_cnt;
endmodule

// File: doc/reg_alu_seq.md
Name: reg_alu_seq

Overview:
- Multi-cycle execute/write-back sequencer that sits directly downstream of the 32x32 register file.
- Accepts one R-type operation through a valid/ready handshake. Drives the register-file read addresses and latches the two operands.
- Computes the ALU result, then drives the register-file write port for exactly one cycle.
- Result and status flags are also exported to the surrounding lab top level (LEDs / display).

Parameters:
- DATA_W, 32, operand/result width (register-file data width).
- ADDR_W, 5, register address width.
- CNT_W, 16, width of the retired-operation counter.

Ports:
- clk_Regs  in  1  clock, shared with the register file.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operation request.
- in_ready  out  1  sequencer can accept an operation.
- rs  in  ADDR_W  source A register.
- rt  in  ADDR_W  source B register.
- rd  in  ADDR_W  destination register.
- alu_op  in  3  operation select.
- R_Addr_A  out  ADDR_W  register-file read address A.
- R_Addr_B  out  ADDR_W  register-file read address B.
- R_Data_A  in  DATA_W  register-file read data A (combinational in the register file).
- R_Data_B  in  DATA_W  register-file read data B.
- Reg_Write  out  1  register-file write enable.
- W_Addr  out  ADDR_W  register-file write address.
- W_Data  out  DATA_W  register-file write data.
- done  out  1  one-cycle pulse when an operation retires.
- result  out  DATA_W  last computed result.
- ZF  out  1  zero flag.
- OF  out  1  signed overflow flag.
- CF  out  1  carry/borrow flag.
- retired_cnt  out  CNT_W  count of retired operations.

Behaviour:
- Reset (asynchronous, any state):
  - State returns to IDLE; any captured operation is discarded, with no write and no done.
  - Outputs: in_ready=1; Reg_Write=0; done=0; all address, data, result and flag outputs 0; retired_cnt=0.
- FSM states: IDLE -> READ -> EXEC -> WB -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at a clock edge: capture rs, rt, rd, alu_op; go to READ.
  - No capture while in_ready=0; in_valid is ignored outside IDLE.
- READ:
  - R_Addr_A=rs and R_Addr_B=rt (registered, held stable until the next capture).
  - At the edge, latch R_Data_A/R_Data_B into opA/opB; go to EXEC.
- EXEC: compute on opA/opB; register result and flags at the edge; go to WB.
- WB:
  - W_Addr=rd and W_Data=result.
  - Reg_Write=1 for this single cycle, only if rd!=0. For rd=0, Reg_Write=0 but done still pulses.
  - done=1; retired_cnt increments.
  - Next state IDLE.
- Latency: acceptance edge to done = 3 cycles. Throughput is one operation per 4 cycles, with in_ready high for one cycle between operations.
- alu_op encoding:
  - 000 AND; 001 OR; 010 XOR; 011 NOR.
  - 100 ADD; 101 SUB (A-B).
  - 110 SLT (signed A<B -> 1, else 0).
  - 111 SLL (B << A[4:0]).
- Flags:
  - ZF = (result==0) for all ops.
  - CF: ADD carry-out of bit DATA_W-1; SUB borrow (A<B unsigned); 0 otherwise.
  - OF: signed overflow for ADD/SUB only; 0 otherwise.
  - Flags and result hold until the next EXEC.
- Arithmetic is performed in DATA_W+1 bits; the result is truncated to DATA_W (wrap-around).
- retired_cnt wraps from 2^CNT_W-1 to 0.
- rs==rt is legal: both operands read the same value.
- rd equal to rs/rt is legal: operands are already latched, so the write does not disturb the current operation.
- Back-to-back dependent operations see the previous result, because its write occurs in WB before the next READ.

Optional Feature:
- Macro: REG_ALU_SEQ_OVF_TRAP_EN.
- When defined: for ADD/SUB with OF=1, WB suppresses Reg_Write (destination unchanged). done still pulses, and an extra output ovf_trap (1 bit) pulses in the same cycle. retired_cnt still increments.
- When undefined: overflow only sets OF, the write proceeds normally, and the ovf_trap port does not exist.

Test Plan:
- Reset: rst_n=0 mid-EXEC -> immediately in_ready=1, Reg_Write=0, done=0, retired_cnt=0, and no write occurs after release.
- ADD: r1=5, r2=7, rs=1 rt=2 rd=3 op=100 -> done 3 cycles after acceptance; Reg_Write=1, W_Addr=3, W_Data=12; ZF=0 CF=0 OF=0.
- SUB borrow/zero:
  - r1=3, r2=5, op=101 -> result=0xFFFFFFFE, CF=1, OF=0.
  - r1=r2=9 -> result=0, ZF=1.
- Overflow: r1=0x7FFFFFFF, r2=1, ADD rd=4 -> OF=1, result=0x80000000.
  - Macro undefined: Reg_Write=1.
  - Macro defined: Reg_Write=0 and ovf_trap=1.
- rd=0: OR into r0 -> done=1, Reg_Write=0 throughout, result still valid.
- Handshake: hold in_valid=1 for 10 cycles -> exactly 3 operations accepted (in_ready high only in IDLE), retired_cnt reaches 3 after the last WB. SLL with A=4, B=1 -> 16; SLT with A=-1, B=0 -> 1.
